// File: rtl/ila_capture_buffer.sv
// ILA capture buffer: a circular sample RAM with a programmable pre-trigger window and a
// lane-selected trigger. After a capture the samples are read back oldest-first.
//
// state | meaning
// IDLE  | waiting for start_i; read side empty
// PRE   | filling the pre-trigger window; the trigger is not evaluated
// ARMED | writing samples and evaluating the trigger on each one
// POST  | writing the post-trigger samples
// DONE  | one cycle: set up the read pointer and count
// READ  | draining the RAM in order on pop_i
module ila_capture_buffer #(
    parameter int WIDTH     = 5,
    parameter int WIDTH_cnt = 3,
    parameter int ADDR_W    = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start_i,
    input  logic                       sample_en_i,
    input  logic [WIDTH*WIDTH_cnt-1:0] DI,
    input  logic [ADDR_W-1:0]          pre_trig_i,
    input  logic [5:0]                 trigger_row,
    input  logic [WIDTH-1:0]           trig_val_i,
    input  logic [WIDTH-1:0]           trig_mask_i,
    input  logic [1:0]                 trig_mode_i,
    input  logic                       pop_i,
    output logic [WIDTH*WIDTH_cnt-1:0] DO,
    output logic                       valid_o,
    output logic                       EMPTY_o,
    output logic                       busy_o,
    output logic                       triggered_o,
    output logic                       done_o,
    output logic [ADDR_W-1:0]          trig_addr_o,
    output logic [WIDTH-1:0]           trigger_out
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int DW    = WIDTH * WIDTH_cnt;

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_ARMED, S_POST, S_DONE, S_READ} state_t;

    state_t              state;
    logic [DW-1:0]       mem [DEPTH];
    logic [ADDR_W-1:0]   wr_ptr;
    logic [ADDR_W-1:0]   rd_ptr;
    logic [ADDR_W:0]     rd_cnt;
    logic [ADDR_W-1:0]   remain;
    logic [ADDR_W-1:0]   cfg_pre;
    logic [5:0]          cfg_row;
    logic [WIDTH-1:0]    cfg_val;
    logic [WIDTH-1:0]    cfg_mask;
    logic [1:0]          cfg_mode;
    logic                prev;
    logic [WIDTH-1:0]    lane;
    logic                match;
    logic                hit;
    logic                wr_en;
    logic [ADDR_W-1:0]   post_len;

    // Any row that does not name an existing lane falls back to lane 0.
    always_comb begin
        lane = DI[WIDTH-1:0];
        for (int i = 0; i < WIDTH_cnt; i++) begin
            if (cfg_row == 6'(i)) lane = DI[i*WIDTH +: WIDTH];
        end
    end

    assign trigger_out = lane;
    assign match       = (((lane ^ cfg_val) & cfg_mask) == '0);

    always_comb begin
        case (cfg_mode)
            2'd0:    hit = match;
            2'd1:    hit = match & ~prev;
            2'd2:    hit = ~match & prev;
            default: hit = 1'b1;
        endcase
    end

    // An ADDR_W-bit pre-trigger count can never exceed DEPTH-1, so no clamp is needed.
    assign post_len = {ADDR_W{1'b1}} - cfg_pre;
    assign wr_en    = !rst && sample_en_i &&
                      (state == S_PRE || state == S_ARMED || state == S_POST);
    assign busy_o   = (state == S_PRE || state == S_ARMED || state == S_POST);

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= DI;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            rd_cnt      <= '0;
            remain      <= '0;
            cfg_pre     <= '0;
            cfg_row     <= '0;
            cfg_val     <= '0;
            cfg_mask    <= '0;
            cfg_mode    <= '0;
            prev        <= 1'b0;
            DO          <= '0;
            valid_o     <= 1'b0;
            EMPTY_o     <= 1'b1;
            triggered_o <= 1'b0;
            done_o      <= 1'b0;
            trig_addr_o <= '0;
        end else begin
            valid_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        wr_ptr   <= '0;
                        remain   <= pre_trig_i;
                        cfg_pre  <= pre_trig_i;
                        cfg_row  <= trigger_row;
                        cfg_val  <= trig_val_i;
                        cfg_mask <= trig_mask_i;
                        cfg_mode <= trig_mode_i;
                        prev     <= (trig_mode_i == 2'd1);
                        state    <= (pre_trig_i == '0) ? S_ARMED : S_PRE;
                    end
                end
                S_PRE: begin
                    if (sample_en_i) begin
                        wr_ptr <= wr_ptr + 1'b1;
                        remain <= remain - 1'b1;
                        if (remain == ADDR_W'(1)) begin
                            prev  <= (cfg_mode == 2'd1);
                            state <= S_ARMED;
                        end
                    end
                end
                S_ARMED: begin
                    if (sample_en_i) begin
                        wr_ptr <= wr_ptr + 1'b1;
                        prev   <= match;
                        if (hit) begin
                            trig_addr_o <= wr_ptr;
                            triggered_o <= 1'b1;
                            remain      <= post_len;
                            state       <= (post_len == '0) ? S_DONE : S_POST;
                        end
                    end
                end
                S_POST: begin
                    if (sample_en_i) begin
                        wr_ptr <= wr_ptr + 1'b1;
                        remain <= remain - 1'b1;
                        if (remain == ADDR_W'(1)) state <= S_DONE;
                    end
                end
                S_DONE: begin
                    rd_ptr  <= trig_addr_o - cfg_pre;
                    rd_cnt  <= (ADDR_W+1)'(DEPTH);
                    EMPTY_o <= 1'b0;
                    done_o  <= 1'b1;
                    state   <= S_READ;
                end
                S_READ: begin
                    if (pop_i && !EMPTY_o) begin
                        DO      <= mem[rd_ptr];
                        valid_o <= 1'b1;
                        rd_ptr  <= rd_ptr + 1'b1;
                        rd_cnt  <= rd_cnt - 1'b1;
                        if (rd_cnt == (ADDR_W+1)'(1)) begin
                            EMPTY_o     <= 1'b1;
                            done_o      <= 1'b0;
                            triggered_o <= 1'b0;
                            state       <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ila_capture_buffer.sv
// Bench for ila_capture_buffer (ADDR_W=4): table of capture scenarios plus hand-written
// sequences for the never-trigger, reset-mid-capture and gated-enable cases.
module tb_ila_capture_buffer;
    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic        sample_en_i;
    logic [14:0] DI;
    logic [3:0]  pre_trig_i;
    logic [5:0]  trigger_row;
    logic [4:0]  trig_val_i;
    logic [4:0]  trig_mask_i;
    logic [1:0]  trig_mode_i;
    logic        pop_i;
    logic [14:0] DO;
    logic        valid_o;
    logic        EMPTY_o;
    logic        busy_o;
    logic        triggered_o;
    logic        done_o;
    logic [3:0]  trig_addr_o;
    logic [4:0]  trigger_out;

    int checks   = 0;
    int failures = 0;

    ila_capture_buffer #(.WIDTH(5), .WIDTH_cnt(3), .ADDR_W(4)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .sample_en_i(sample_en_i), .DI(DI),
        .pre_trig_i(pre_trig_i), .trigger_row(trigger_row), .trig_val_i(trig_val_i),
        .trig_mask_i(trig_mask_i), .trig_mode_i(trig_mode_i), .pop_i(pop_i), .DO(DO),
        .valid_o(valid_o), .EMPTY_o(EMPTY_o), .busy_o(busy_o), .triggered_o(triggered_o),
        .done_o(done_o), .trig_addr_o(trig_addr_o), .trigger_out(trigger_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] pre;
        logic [5:0] row;
        logic [4:0] val;
        logic [4:0] mask;
        logic [1:0] mode;
        int         trig_n;
        logic [3:0] addr;
        int         first_n;
    } vec_t;

    vec_t tbl [6];

    function automatic logic [14:0] mk(input int n);
        logic [4:0] l0, l1, l2;
        l0 = 5'(n % 32);
        l1 = 5'((n + 1) % 32);
        l2 = 5'((n + 2) % 32);
        return {l2, l1, l0};
    endfunction

    function automatic logic [4:0] lane_of(input logic [5:0] row, input int n);
        int k;
        k = (row < 6'd3) ? int'(row) : 0;
        return 5'((n + k) % 32);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start_i = 1'b0; sample_en_i = 1'b0; pop_i = 1'b0; DI = '0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic arm(input logic [3:0] pre, input logic [5:0] row, input logic [4:0] val,
                       input logic [4:0] mask, input logic [1:0] mode);
        pre_trig_i = pre; trigger_row = row; trig_val_i = val;
        trig_mask_i = mask; trig_mode_i = mode;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic sample(input int n);
        sample_en_i = 1'b1;
        DI = mk(n);
        tick();
        sample_en_i = 1'b0;
    endtask

    task automatic read_all(input int first_n);
        for (int i = 0; i < 16; i++) begin
            pop_i = 1'b1;
            tick();
            pop_i = 1'b0;
            chk("read_valid", 32'(valid_o), 32'd1);
            chk("read_data", 32'(DO), 32'(mk(first_n + i)));
        end
        chk("empty_after_read", 32'(EMPTY_o), 32'd1);
        chk("done_cleared", 32'(done_o), 32'd0);
        chk("trig_cleared", 32'(triggered_o), 32'd0);
        pop_i = 1'b1;
        tick();
        pop_i = 1'b0;
        chk("pop_empty_no_valid", 32'(valid_o), 32'd0);
    endtask

    initial begin
        int n, tn, cyc;
        bit seen;

        tbl[0] = '{4'd4,  6'd1, 5'h16, 5'h1F, 2'd0, 21, 4'd5,  17};
        tbl[1] = '{4'd0,  6'd0, 5'h00, 5'h00, 2'd3, 0,  4'd0,  0};
        tbl[2] = '{4'd0,  6'd0, 5'h03, 5'h1F, 2'd1, 3,  4'd3,  3};
        tbl[3] = '{4'd15, 6'd0, 5'h00, 5'h00, 2'd3, 15, 4'd15, 0};
        tbl[4] = '{4'd3,  6'd2, 5'h10, 5'h1F, 2'd2, 15, 4'd15, 12};
        tbl[5] = '{4'd5,  6'd2, 5'h00, 5'h03, 2'd0, 6,  4'd6,  1};

        pre_trig_i = '0; trigger_row = '0; trig_val_i = '0; trig_mask_i = '0; trig_mode_i = '0;
        do_reset();
        chk("rst_DO", 32'(DO), 32'd0);
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_empty", 32'(EMPTY_o), 32'd1);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_triggered", 32'(triggered_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_trig_addr", 32'(trig_addr_o), 32'd0);

        foreach (tbl[i]) begin
            do_reset();
            arm(tbl[i].pre, tbl[i].row, tbl[i].val, tbl[i].mask, tbl[i].mode);
            chk("busy_after_start", 32'(busy_o), 32'd1);
            DI = mk(7);
            #1;
            chk("trigger_out", 32'(trigger_out), 32'(lane_of(tbl[i].row, 7)));
            n = 0; seen = 0; tn = -1;
            while (!seen && n < 64) begin
                sample(n);
                if (triggered_o) begin seen = 1; tn = n; end
                n++;
            end
            chk("trig_sample", 32'(tn), 32'(tbl[i].trig_n));
            chk("trig_addr", 32'(trig_addr_o), 32'(tbl[i].addr));
            cyc = 0;
            while (!done_o && cyc < 40) begin
                sample(n);
                n++; cyc++;
            end
            chk("done_set", 32'(done_o), 32'd1);
            chk("not_empty", 32'(EMPTY_o), 32'd0);
            chk("busy_in_read", 32'(busy_o), 32'd0);
            read_all(tbl[i].first_n);
        end

        // Rising edge on an always-true condition must never fire.
        do_reset();
        arm(4'd0, 6'd0, 5'h00, 5'h00, 2'd1);
        for (int k = 0; k < 40; k++) sample(k);
        chk("never_trig", 32'(triggered_o), 32'd0);
        chk("never_busy", 32'(busy_o), 32'd1);
        pop_i = 1'b1;
        tick();
        pop_i = 1'b0;
        chk("never_pop_valid", 32'(valid_o), 32'd0);
        chk("never_empty", 32'(EMPTY_o), 32'd1);

        // Reset in the middle of POST discards the capture.
        do_reset();
        arm(4'd0, 6'd0, 5'h00, 5'h00, 2'd3);
        for (int k = 0; k < 5; k++) sample(k);
        chk("post_busy", 32'(busy_o), 32'd1);
        chk("post_triggered", 32'(triggered_o), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy", 32'(busy_o), 32'd0);
        chk("midrst_empty", 32'(EMPTY_o), 32'd1);
        chk("midrst_done", 32'(done_o), 32'd0);
        chk("midrst_triggered", 32'(triggered_o), 32'd0);
        pop_i = 1'b1;
        tick();
        pop_i = 1'b0;
        chk("midrst_pop_valid", 32'(valid_o), 32'd0);
        sample(0);
        chk("midrst_sample_idle", 32'(busy_o), 32'd0);

        // Out-of-range row falls back to lane 0; gap cycles carry a matching value.
        do_reset();
        arm(4'd2, 6'd7, 5'h05, 5'h1F, 2'd0);
        DI = mk(9);
        #1;
        chk("row7_trigger_out", 32'(trigger_out), 32'd9);
        n = 0; seen = 0; tn = -1;
        while (!seen && n < 64) begin
            sample_en_i = 1'b0;
            DI = {3{5'h05}};
            tick();
            if (triggered_o) begin seen = 1; tn = -2; end
            if (!seen) begin
                sample(n);
                if (triggered_o) begin seen = 1; tn = n; end
                n++;
            end
        end
        chk("gated_trig_sample", 32'(tn), 32'd5);
        chk("gated_trig_addr", 32'(trig_addr_o), 32'd5);
        cyc = 0;
        while (!done_o && cyc < 80) begin
            sample_en_i = 1'b0;
            DI = {3{5'h05}};
            tick();
            if (!done_o) begin
                sample(n);
                n++;
            end
            cyc++;
        end
        chk("gated_done", 32'(done_o), 32'd1);
        read_all(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
